// File: rtl/mod_updown_counter_if.sv
// Control/status bundle for mod_updown_counter: the controller side drives
// clr/ld/en/up, the counter side returns cnt, tc and wrap.
interface mod_updown_counter_if #(
  parameter int WIDTH = 4
);
  logic             clr;
  logic             ld;
  logic [WIDTH-1:0] ld_val;
  logic             en;
  logic             up;
  logic [WIDTH-1:0] cnt;
  logic             tc;
  logic             wrap;

  modport master (
    output clr, ld, ld_val, en, up,
    input  cnt, tc, wrap
  );

  modport slave (
    input  clr, ld, ld_val, en, up,
    output cnt, tc, wrap
  );
endinterface

// File: rtl/mod_updown_counter.sv
// Parametrised modulo-N up/down counter with clear, clamped load, cascadable
// terminal count and a sticky wrap flag.
module mod_updown_counter #(
  parameter int WIDTH  = 4,
  parameter int MODULO = 12,
  parameter int INIT   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  mod_updown_counter_if.slave  bus
);

  // Reject illegal parameter sets at elaboration time.
  generate
    if (WIDTH < 1 || MODULO < 2 || longint'(MODULO) > (longint'(1) << WIDTH)) begin : g_bad_modulo
      $error("mod_updown_counter: MODULO must satisfy 2 <= MODULO <= 2**WIDTH");
    end
    if (INIT < 0 || INIT >= MODULO) begin : g_bad_init
      $error("mod_updown_counter: INIT must be in 0..MODULO-1");
    end
    if ($bits(bus.cnt) != WIDTH) begin : g_bad_if_width
      $error("mod_updown_counter: interface WIDTH does not match counter WIDTH");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_CNT  = WIDTH'(MODULO - 1);
  localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH + 1)'(MODULO);
  localparam logic [WIDTH-1:0] INIT_VAL = WIDTH'(INIT);

  logic [WIDTH-1:0] cnt_reg;
  logic [WIDTH-1:0] cnt_next;
  logic             wrap_reg;
  logic             wrap_next;
  logic             at_top;
  logic             at_bot;
  logic             hit;

  // Explicit compares even when MODULO is a power of two, so cnt can never
  // leave 0..MODULO-1 regardless of parameters.
  assign at_top = (cnt_reg == MAX_CNT);
  assign at_bot = (cnt_reg == '0);
  assign hit    = bus.up ? at_top : at_bot;

  always_comb begin
    cnt_next  = cnt_reg;
    wrap_next = wrap_reg;
    if (bus.clr) begin
      cnt_next  = '0;
      wrap_next = 1'b0;
    end else if (bus.ld) begin
      // Out-of-range loads clamp to the top of the range.
      if ({1'b0, bus.ld_val} < MOD_EXT) begin
        cnt_next = bus.ld_val;
      end else begin
        cnt_next = MAX_CNT;
      end
    end else if (bus.en) begin
      if (hit) begin
        cnt_next  = bus.up ? '0 : MAX_CNT;
        wrap_next = 1'b1;
      end else if (bus.up) begin
        cnt_next = cnt_reg + WIDTH'(1);
      end else begin
        cnt_next = cnt_reg - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg  <= INIT_VAL;
      wrap_reg <= 1'b0;
    end else begin
      cnt_reg  <= cnt_next;
      wrap_reg <= wrap_next;
    end
  end

  // Zero-latency so a downstream stage advances on the same edge this one wraps.
  assign bus.tc   = bus.en & ~bus.clr & ~bus.ld & hit & ~rst;
  assign bus.cnt  = cnt_reg;
  assign bus.wrap = wrap_reg;

endmodule

// File: doc/mod_updown_counter.md
Name: mod_updown_counter

Overview:
- Parametrised modulo-N counter. Successor to the fixed 4-bit mod-12 enable counter.
- Adds up/down mode, synchronous clear, parallel load with range clamp, terminal-count output for cascading, and a sticky wrap flag.
- Used as a timing/sequence counter. Instances chain through tc -> en to build wider counters.

Parameters:
- WIDTH, 4, counter width in bits.
- MODULO, 12, count range 0..MODULO-1. Legal range is 2 <= MODULO <= 2**WIDTH. Any other value is an elaboration error via a generate-time check.
- INIT, 0, value loaded on reset. Must be < MODULO.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous clear to 0.
- ld  in  1  synchronous parallel load.
- ld_val  in  WIDTH  load value.
- en  in  1  count enable. Ties to the upstream tc when cascading.
- up  in  1  direction: 1 = up, 0 = down.
- cnt  out  WIDTH  registered count.
- tc  out  1  combinational terminal count. High when the next enabled edge wraps.
- wrap  out  1  registered sticky flag. Set on any wrap.

Behaviour:
- Reset:
  - rst high forces cnt=INIT and wrap=0 immediately, with no clock needed.
  - The counter is held there while rst stays high.
  - Reset mid-count aborts the count. Counting resumes from INIT on the first rising edge after rst falls.
- Per rising edge, priority rst > clr > ld > en:
  - clr=1: cnt<=0, wrap<=0. ld and en are ignored.
  - ld=1: cnt<=ld_val if ld_val<MODULO, else cnt<=MODULO-1 (clamp). wrap is unchanged. en is ignored.
  - en=1, up=1: if cnt==MODULO-1 then cnt<=0 and wrap<=1; else cnt<=cnt+1.
  - en=1, up=0: if cnt==0 then cnt<=MODULO-1 and wrap<=1; else cnt<=cnt-1.
  - en=0 and no clr/ld: cnt and wrap hold.
- tc:
  - tc = en & ~clr & ~ld & ((up & cnt==MODULO-1) | (~up & cnt==0)).
  - tc is purely combinational from current inputs and cnt, with zero latency, so a downstream stage advances on the same edge the upstream wraps.
  - tc is 0 while rst=1.
- Latency: cnt updates one edge after en/ld/clr is sampled.
- Direction change takes effect on the edge where the new up is sampled. There is no pipeline and no dead cycle.
- Arithmetic:
  - Compare and increment at WIDTH bits.
  - When MODULO==2**WIDTH, natural overflow is equivalent, but the explicit compare is still used.
  - cnt must never hold a value >= MODULO.
- Simultaneous events:
  - clr with a wrap condition: clr wins and wrap ends 0.
  - ld with a wrap condition: load wins and wrap is not set.
- wrap clears only on rst or clr.

Test Plan:
- Reset/hold: rst=1 mid-cycle -> cnt=0 and wrap=0 asynchronously. Release rst with en=0 for 3 cycles -> cnt stays 0.
- Up count, defaults (WIDTH=4, MODULO=12): en=1, up=1 for 14 cycles -> cnt 1,2,...,11,0,1,2. tc=1 only while cnt=11. wrap rises on the edge cnt goes 11->0.
- Down count: ld_val=2 with ld=1, then en=1, up=0 for 4 cycles -> cnt 2,1,0,11,10. tc=1 while cnt=0. wrap=1 afterwards.
- Load clamp and priority: ld=1, ld_val=15 -> cnt=11. Then ld=1, clr=1 together -> cnt=0, wrap=0. Then en=1 with ld=1, ld_val=5 -> cnt=5, not incremented.
- Cascade: two instances, low.tc -> high.en, both MODULO=12, counted up 150 cycles from 0 -> high.cnt=12 mod-wraps to 0 at 144, so high=0, low=6. high.wrap=1.
- Async reset mid-operation: count to 7, assert rst between edges -> cnt=0 immediately. Deassert -> counting restarts 1,2,... on the following edges. Parameter sweep at WIDTH=3, MODULO=8 gives cnt 0..7 wrap.
